// File: rtl/regfile_sequencer_pkg.sv
// ============================================================================
// regfile_sequencer_pkg : shared op/state encodings and width defaults
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_sequencer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_MOVE  = 2'b10,
    OP_SWAP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_B = 3'd4,
    ST_RESP = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_sequencer.sv
// ============================================================================
// regfile_sequencer : sequences READ/WRITE/MOVE/SWAP over a 1-port register file
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_ra,
  input  logic [ADDR_W-1:0] req_rb,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_a,
  output logic [DATA_W-1:0] rsp_b,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_din,
  input  logic [DATA_W-1:0] rf_dout
);

  state_e              r_state;
  op_e                 r_op;
  logic [ADDR_W-1:0]   r_ra;
  logic [ADDR_W-1:0]   r_rb;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_a;
  logic [DATA_W-1:0]   r_rsp_b;
  logic [ADDR_W-1:0]   r_rf_addr;
  logic                r_rf_we;
  logic [DATA_W-1:0]   r_rf_din;

  // Register-file drive is computed for the state being entered, so every
  // output is a flop and drops to zero the instant reset asserts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_READ;
      r_ra        <= '0;
      r_rb        <= '0;
      r_wdata     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_a     <= '0;
      r_rsp_b     <= '0;
      r_rf_addr   <= '0;
      r_rf_we     <= 1'b0;
      r_rf_din    <= '0;
    end else begin
      r_rf_addr <= '0;
      r_rf_we   <= 1'b0;
      r_rf_din  <= '0;
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (r_req_ready && req_valid) begin
            r_req_ready <= 1'b0;
            r_op        <= op_e'(req_op);
            r_ra        <= req_ra;
            r_rb        <= req_rb;
            r_wdata     <= req_wdata;
            r_rf_addr   <= req_ra;
            if (op_e'(req_op) == OP_WRITE) begin
              r_state  <= ST_WR_A;
              r_rf_we  <= 1'b1;
              r_rf_din <= req_wdata;
            end else begin
              r_state <= ST_RD_A;
            end
          end
        end
        ST_RD_A: begin
          r_a       <= rf_dout;
          r_rf_addr <= r_rb;
          if (r_op == OP_MOVE) begin
            r_state  <= ST_WR_B;
            r_rf_we  <= 1'b1;
            r_rf_din <= rf_dout;
          end else begin
            r_state <= ST_RD_B;
          end
        end
        ST_RD_B: begin
          r_b <= rf_dout;
          if (r_op == OP_SWAP) begin
            r_state   <= ST_WR_A;
            r_rf_addr <= r_ra;
            r_rf_we   <= 1'b1;
            r_rf_din  <= rf_dout;
          end else begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_a     <= r_a;
            r_rsp_b     <= rf_dout;
          end
        end
        ST_WR_A: begin
          if (r_op == OP_SWAP) begin
            r_state   <= ST_WR_B;
            r_rf_addr <= r_rb;
            r_rf_we   <= 1'b1;
            r_rf_din  <= r_a;
          end else begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_a     <= r_wdata;
            r_rsp_b     <= '0;
          end
        end
        ST_WR_B: begin
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_a     <= r_a;
          r_rsp_b     <= (r_op == OP_SWAP) ? r_b : '0;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_a     = r_rsp_a;
  assign rsp_b     = r_rsp_b;
  assign rf_addr   = r_rf_addr;
  assign rf_we     = r_rf_we;
  assign rf_din    = r_rf_din;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
// ============================================================================
// tb_regfile_sequencer : directed vector bench with a behavioural register file
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sequencer;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_ra;
  logic [AW-1:0] req_rb;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_a;
  logic [DW-1:0] rsp_b;
  logic [AW-1:0] rf_addr;
  logic          rf_we;
  logic [DW-1:0] rf_din;
  logic [DW-1:0] rf_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_chk  = 0;
  int n_fail = 0;

  regfile_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_ra    (req_ra),
    .req_rb    (req_rb),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_a     (rsp_a),
    .rsp_b     (rsp_b),
    .rf_addr   (rf_addr),
    .rf_we     (rf_we),
    .rf_din    (rf_din),
    .rf_dout   (rf_dout)
  );

  always #5 clock = ~clock;

  // Far-end register file: combinational read, write on the rising edge.
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
  assign rf_dout = mem[rf_addr];
  always @(posedge clock) if (rf_we) mem[rf_addr] <= rf_din;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic [DW-1:0] wd, input int stall,
                       output int lat, output logic [DW-1:0] a, output logic [DW-1:0] b,
                       output int wecnt, output logic [AW-1:0] waddr);
    int guard;
    bit done;
    lat = 0; a = '0; b = '0; wecnt = 0; waddr = '0; done = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_op = op; req_ra = ra; req_rb = rb; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    chk("accept", 32'(req_ready), 32'd1);
    if (req_ready) begin
      @(posedge clock);
      #1 req_valid = 1'b0;
      for (int n = 1; n <= 30 && !done; n++) begin
        @(negedge clock);
        if (rf_we) begin
          if (wecnt == 0) waddr = rf_addr;
          wecnt++;
        end
        if (rsp_valid) begin
          if (lat == 0) begin
            lat = n; a = rsp_a; b = rsp_b;
          end else begin
            chk("hold_a", 32'(rsp_a), 32'(a));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
          end
          if (n - lat >= stall) begin
            rsp_ready = 1'b1;
            @(posedge clock);
            #1 rsp_ready = 1'b0;
            done = 1'b1;
            chk("rsp_drop", 32'(rsp_valid), 32'd0);
          end
        end
      end
      chk("rsp_seen", 32'(done), 32'd1);
    end else begin
      req_valid = 1'b0;
    end
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] wd;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    int            elat;
    int            ewe;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int lat, wecnt, guard;
    logic [DW-1:0] a, b;
    logic [AW-1:0] waddr, ewaddr;

    // op, ra, rb, wdata, exp rsp_a, exp rsp_b, latency, write cycles
    vecs[0]  = '{2'b01, 3'd3, 3'd0, 8'hA5, 8'hA5, 8'h00, 2, 1};
    vecs[1]  = '{2'b01, 3'd1, 3'd0, 8'h11, 8'h11, 8'h00, 2, 1};
    vecs[2]  = '{2'b01, 3'd2, 3'd0, 8'h22, 8'h22, 8'h00, 2, 1};
    vecs[3]  = '{2'b00, 3'd1, 3'd2, 8'h00, 8'h11, 8'h22, 3, 0};
    vecs[4]  = '{2'b11, 3'd1, 3'd2, 8'h00, 8'h11, 8'h22, 5, 2};
    vecs[5]  = '{2'b00, 3'd1, 3'd2, 8'h00, 8'h22, 8'h11, 3, 0};
    vecs[6]  = '{2'b01, 3'd4, 3'd0, 8'h5C, 8'h5C, 8'h00, 2, 1};
    vecs[7]  = '{2'b11, 3'd4, 3'd4, 8'h00, 8'h5C, 8'h5C, 5, 2};
    vecs[8]  = '{2'b00, 3'd4, 3'd3, 8'h00, 8'h5C, 8'hA5, 3, 0};
    vecs[9]  = '{2'b10, 3'd3, 3'd6, 8'h00, 8'hA5, 8'h00, 3, 1};
    vecs[10] = '{2'b00, 3'd6, 3'd6, 8'h00, 8'hA5, 8'hA5, 3, 0};
    vecs[11] = '{2'b10, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3, 1};
    vecs[12] = '{2'b01, 3'd2, 3'd0, 8'h22, 8'h22, 8'h00, 2, 1};

    reset = 1'b0; req_valid = 1'b0; req_op = '0; req_ra = '0; req_rb = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rf_we",     32'(rf_we),     32'd0);
    chk("rst_rf_addr",   32'(rf_addr),   32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_a",     32'(rsp_a),     32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].wd, 0, lat, a, b, wecnt, waddr);
      chk($sformatf("v%0d_lat", i),   32'(lat),   32'(vecs[i].elat));
      chk($sformatf("v%0d_rsp_a", i), 32'(a),     32'(vecs[i].ea));
      chk($sformatf("v%0d_rsp_b", i), 32'(b),     32'(vecs[i].eb));
      chk($sformatf("v%0d_we", i),    32'(wecnt), 32'(vecs[i].ewe));
      ewaddr = (vecs[i].op == 2'b10) ? vecs[i].rb : vecs[i].ra;
      if (vecs[i].ewe > 0) chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(ewaddr));
    end

    // MOVE with a stalled consumer: response must hold for four cycles.
    do_op(2'b10, 3'd2, 3'd5, 8'h00, 4, lat, a, b, wecnt, waddr);
    chk("stall_lat",   32'(lat), 32'd3);
    chk("stall_rsp_a", 32'(a),   32'h22);
    chk("stall_rsp_b", 32'(b),   32'h00);
    do_op(2'b00, 3'd5, 3'd2, 8'h00, 0, lat, a, b, wecnt, waddr);
    chk("move_r5", 32'(a), 32'h22);
    chk("move_r2", 32'(b), 32'h22);

    // Reset during SWAP WR_A: the pending write must be dropped.
    @(negedge clock);
    req_valid = 1'b1; req_op = 2'b11; req_ra = 3'd1; req_rb = 3'd3;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    chk("swap_accept", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("wr_a_we",   32'(rf_we),   32'd1);
    chk("wr_a_addr", 32'(rf_addr), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_we",        32'(rf_we),     32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("release_ready", 32'(req_ready), 32'd1);
    chk("release_rsp",   32'(rsp_valid), 32'd0);
    do_op(2'b00, 3'd1, 3'd3, 8'h00, 0, lat, a, b, wecnt, waddr);
    chk("abort_r1", 32'(a), 32'h22);
    chk("abort_r3", 32'(b), 32'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the register data width.
REQ-002 Parameter ADDR_W, default 3, SHALL set the register index width.
REQ-003 Port clock, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: SHALL be asynchronous, active-low.
REQ-005 Port req_valid, input, 1: SHALL flag a valid request from decode.
REQ-006 Port req_ready, output, 1: SHALL flag that the sequencer accepts a request this cycle.
REQ-007 Port req_op, input, 2: SHALL select the operation: 00 READ, 01 WRITE, 10 MOVE, 11 SWAP.
REQ-008 Ports req_ra and req_rb, input, ADDR_W each: SHALL be the operand register indices.
REQ-009 Port req_wdata, input, DATA_W: SHALL be the WRITE data.
REQ-010 Port rsp_valid, output, 1: SHALL flag a completed operation.
REQ-011 Port rsp_ready, input, 1: SHALL flag that the consumer takes the response.
REQ-012 Ports rsp_a and rsp_b, output, DATA_W each: SHALL be the result values.
REQ-013 Ports rf_addr (output, ADDR_W), rf_we (output, 1), rf_din (output, DATA_W): SHALL drive the register file.
REQ-014 Port rf_dout, input, DATA_W: SHALL be register file read data, valid by the rising edge that ends the read cycle.

Function
REQ-015 States SHALL be IDLE, RD_A, RD_B, WR_A, WR_B, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1, and all req_* fields are captured there.
REQ-017 Sequences after acceptance: READ = RD_A, RD_B, RESP; WRITE = WR_A, RESP; MOVE = RD_A, WR_B, RESP; SWAP = RD_A, RD_B, WR_A, WR_B, RESP.
REQ-018 Each RD/WR state SHALL last exactly one cycle, so latency from acceptance to rsp_valid is READ 3, WRITE 2, MOVE 3, SWAP 5 cycles.
REQ-019 RD_A SHALL drive rf_addr=ra and rf_we=0, and capture rf_dout into A at the closing edge; RD_B does the same with rb into B.
REQ-020 WR_A SHALL drive rf_addr=ra and rf_we=1, with rf_din=wdata for WRITE and rf_din=B for SWAP.
REQ-021 WR_B SHALL drive rf_addr=rb, rf_we=1 and rf_din=A.
REQ-022 In IDLE and RESP, rf_we SHALL be 0, rf_addr SHALL be 0 and rf_din SHALL be 0.
REQ-023 Response values:
- READ: rsp_a=old[ra], rsp_b=old[rb].
- WRITE: rsp_a=wdata, rsp_b=0.
- MOVE: rsp_a=old[ra], rsp_b=0.
- SWAP: rsp_a=old[ra], rsp_b=old[rb].
REQ-024 In RESP, rsp_valid=1, and rsp_a/rsp_b SHALL hold stable until an edge with rsp_ready=1; that edge moves the block to IDLE. Outside RESP, rsp_valid=0.
REQ-025 ra==rb SHALL run the full sequence unchanged: READ returns equal values; SWAP leaves the register unchanged; MOVE rewrites the same value.
REQ-026 Back-to-back requests SHALL be permitted; the minimum gap is one IDLE cycle after the RESP hand-off.
REQ-027 rf_we SHALL never be 1 in two states that target the same address within one operation, except SWAP with ra==rb.

Reset
REQ-028 reset=0 SHALL immediately force:
- state to IDLE;
- rf_we, rf_addr, rf_din, rsp_valid, rsp_a, rsp_b, A and B to 0.
REQ-029 req_ready SHALL be 0 while reset=0, and 1 from the first cycle after release.
REQ-030 Reset mid-operation SHALL abandon the operation with no response; a pending write is dropped because rf_we falls asynchronously before the next edge.

Structure
REQ-031 The op encodings, state encodings, DATA_W and ADDR_W defaults SHALL live in the shared CPU definitions package/include.
REQ-032 No sub-module is needed; the testbench SHALL connect the existing register file block as the far end.

Verification
REQ-033 Reset, then WRITE ra=3, wdata=8'hA5 -> rf_we=1 for exactly one cycle with addr 3; rsp_a=8'hA5 two cycles after acceptance.
REQ-034 After r1=8'h11 and r2=8'h22, READ ra=1, rb=2 -> rsp_a=8'h11, rsp_b=8'h22, rsp_valid 3 cycles after acceptance.
REQ-035 SWAP ra=1, rb=2 -> rsp 8'h11/8'h22; a following READ returns r1=8'h22, r2=8'h11.
REQ-036 MOVE ra=2, rb=5, with rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_a stay at 8'h22, req_ready=0 throughout; r5=8'h22 afterwards.
REQ-037 Assert reset during SWAP state WR_A -> rf_we=0 immediately, no rsp_valid, req_ready=1 the cycle after release.
REQ-038 SWAP ra=rb=4 with r4=8'h5C -> rsp_a=rsp_b=8'h5C; r4 unchanged.
